multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL be parametrised as follows (name, default, meaning):
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, ALU-decoder control width.
- MEM_WAIT, 1, 1 = memory states wait on mem_ready; 0 = mem_ready ignored and treated as 1.
- EN_JUMP, 1, 1 = J opcode 6'b000010 supported; 0 = J treated as illegal.
REQ-002 The block SHALL have exactly these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- opcode, in, OPCODE_W, instruction[31:26], sampled in DECODE.
- mem_ready, in, 1, memory access completes this cycle.
- iord, out, 1, memory address select (0 = PC, 1 = ALUOut).
- mem_write, out, 1, memory write strobe.
- ir_write, out, 1, instruction register load.
- pc_write, out, 1, unconditional PC load.
- branch, out, 1, conditional PC load (gated by Zero outside the block).
- pc_src, out, 2, next-PC select (00 ALU, 01 ALUOut, 10 jump target).
- alu_src_a, out, 1, 0 = PC, 1 = register A.
- alu_src_b, out, 2, 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2.
- alu_op, out, ALUOP_W, 00 add, 01 sub, 10 funct-decoded.
- reg_dst, out, 1, 1 = rd, 0 = rt.
- mem_to_reg, out, 1, 1 = data register, 0 = ALUOut.
- reg_write, out, 1, register-file write enable.
- illegal_op, out, 1, one-cycle pulse on an unsupported opcode.
- state_o, out, 4, current state encoding, for debug.

Function
REQ-003 The block SHALL be a single FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP.
REQ-004 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE -> MEMADR for lw (100011) and sw (101011); EXEC for R-type (000000); BRANCH for beq (000100); ADDIEX for addi (001000); JUMP for j (when EN_JUMP=1); else FETCH.
- MEMADR -> MEMRD for lw, MEMWR for sw (opcode held stable by the IR).
- MEMRD -> MEMWB.
- EXEC -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-005 When MEM_WAIT=1, FETCH, MEMRD and MEMWR SHALL hold while mem_ready=0 and advance on the first cycle with mem_ready=1.
REQ-006 Every output not listed for a state SHALL be 0. Outputs SHALL be decoded from the current state only, except the mem_ready qualification stated below.
REQ-007 FETCH SHALL drive:
- iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
- ir_write=1 and pc_write=1 only in the cycle mem_ready=1.
REQ-008 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-009 MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-010 MEMRD SHALL drive iord=1.
REQ-011 MEMWR SHALL drive iord=1, and mem_write=1 for every cycle in the state.
REQ-012 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-013 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-014 ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-015 ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-016 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01.
REQ-017 JUMP SHALL drive pc_write=1, pc_src=10.
REQ-018 illegal_op SHALL pulse for exactly the DECODE cycle in which the opcode is unsupported.
REQ-019 Cycle counts with mem_ready tied 1 SHALL be:
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each extra wait cycle adds one cycle.
REQ-020 When alu_op is wider than 2 bits, the codes SHALL be zero-extended.

Reset
REQ-021 rst=1 SHALL force state FETCH immediately, asynchronously, including mid-instruction and mid-wait.
REQ-022 During reset, all outputs except the FETCH decode SHALL be 0, and ir_write and pc_write SHALL be 0 regardless of mem_ready.
REQ-023 The first FETCH SHALL begin on the first rising clk edge after rst deasserts.

Structure
REQ-024 The state encodings (4-bit, FETCH=0 ... JUMP=11), opcode constants, alu_op codes, pc_src codes and alu_src_b codes SHALL live in the shared package mips_pkg.
REQ-025 The block SHALL contain exactly two processes: a state register and next-state/output decode. No sub-module is required; the existing ALU decoder remains separate and consumes alu_op.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5.
- opcode=101011, mem_ready low for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, then FETCH.
- opcode=000100 -> branch=1, alu_op=01, pc_src=01 in cycle 3, then FETCH.
- opcode=111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH; with EN_JUMP=0, opcode=000010 behaves the same.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 for 2 cycles, then exactly one pulse of each.
- rst asserted in EXEC between clock edges -> state_o=0 immediately and reg_write never asserted.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: controller state
// encodings, opcode constants and the datapath mux/ALU control codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS processor. Outputs are a Moore
// decode of the current state; only the FETCH IR/PC loads and the memory
// wait states look at mem_ready.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int MEM_WAIT = 1,
    parameter int EN_JUMP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op,
    output logic [3:0]          state_o
);

    state_t state_r;
    state_t next_state_s;
    logic   ready_s;

    // State register; reset parks the machine in FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control decode from the current state.
    always_comb begin
        ready_s      = (MEM_WAIT != 0) ? mem_ready : 1'b1;
        next_state_s = state_r;
        state_o      = state_r;
        iord         = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        pc_src       = PCSRC_ALU;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        alu_op       = {ALUOP_W{1'b0}};
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        illegal_op   = 1'b0;

        case (state_r)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_W'(ALUOP_ADD);
                // The IR/PC loads must stay quiet while reset holds the FSM here.
                ir_write  = ready_s & ~rst;
                pc_write  = ready_s & ~rst;
                if (ready_s) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALUOP_W'(ALUOP_ADD);
                if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) begin
                    next_state_s = S_MEMADR;
                end else if (opcode == OPCODE_W'(OP_RTYPE)) begin
                    next_state_s = S_EXEC;
                end else if (opcode == OPCODE_W'(OP_BEQ)) begin
                    next_state_s = S_BRANCH;
                end else if (opcode == OPCODE_W'(OP_ADDI)) begin
                    next_state_s = S_ADDIEX;
                end else if ((EN_JUMP != 0) && (opcode == OPCODE_W'(OP_J))) begin
                    next_state_s = S_JUMP;
                end else begin
                    illegal_op   = 1'b1;
                    next_state_s = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_W'(ALUOP_ADD);
                // The IR still holds the instruction, so opcode is stable here.
                if (opcode == OPCODE_W'(OP_LW)) begin
                    next_state_s = S_MEMRD;
                end else if (opcode == OPCODE_W'(OP_SW)) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (ready_s) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (ready_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_B;
                alu_op       = ALUOP_W'(ALUOP_FUNCT);
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_B;
                alu_op       = ALUOP_W'(ALUOP_SUB);
                branch       = 1'b1;
                pc_src       = PCSRC_ALUOUT;
                next_state_s = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALUOP_W'(ALUOP_ADD);
                next_state_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write    = 1'b1;
                next_state_s = S_FETCH;
            end
            S_JUMP: begin
                pc_write     = 1'b1;
                pc_src       = PCSRC_JUMP;
                next_state_s = S_FETCH;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of per-opcode
// state sequences, directed multi-cycle corner cases, and a randomized run
// against an instruction-level reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic [5:0] opcode;

    logic       iord, mem_write, ir_write, pc_write, branch, alu_src_a;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state_o;

    logic       j_iord, j_mem_write, j_ir_write, j_pc_write, j_branch, j_alu_src_a;
    logic       j_reg_dst, j_mem_to_reg, j_reg_write, j_illegal_op;
    logic [1:0] j_pc_src, j_alu_src_b, j_alu_op;
    logic [3:0] j_state_o;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller #(.OPCODE_W(6), .ALUOP_W(2), .MEM_WAIT(1), .EN_JUMP(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    multicycle_controller #(.OPCODE_W(6), .ALUOP_W(2), .MEM_WAIT(1), .EN_JUMP(0)) dut_nj (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .iord(j_iord), .mem_write(j_mem_write), .ir_write(j_ir_write), .pc_write(j_pc_write),
        .branch(j_branch), .pc_src(j_pc_src), .alu_src_a(j_alu_src_a), .alu_src_b(j_alu_src_b),
        .alu_op(j_alu_op), .reg_dst(j_reg_dst), .mem_to_reg(j_mem_to_reg), .reg_write(j_reg_write),
        .illegal_op(j_illegal_op), .state_o(j_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Hold reset over two edges, release just after a rising edge: the
    // machine is then in its first FETCH cycle.
    task automatic apply_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [5:0] op;
        int         cycles;
        int         seq[6];
        int         ill;
    } vec_t;

    vec_t tbl[7];

    // ---------------- reference model ----------------
    typedef struct {
        int st;
        bit waits;
        bit ill;
    } step_t;

    step_t q[$];

    function automatic step_t mk(input int st, input bit waits, input bit ill);
        step_t s;
        s.st    = st;
        s.waits = waits;
        s.ill   = ill;
        return s;
    endfunction

    // Expand one instruction into its ordered list of controller steps.
    task automatic build_instr(input logic [5:0] op);
        q.push_back(mk(0, 1'b1, 1'b0));
        case (op)
            6'b100011: begin
                q.push_back(mk(1, 1'b0, 1'b0)); q.push_back(mk(2, 1'b0, 1'b0));
                q.push_back(mk(3, 1'b1, 1'b0)); q.push_back(mk(4, 1'b0, 1'b0));
            end
            6'b101011: begin
                q.push_back(mk(1, 1'b0, 1'b0)); q.push_back(mk(2, 1'b0, 1'b0));
                q.push_back(mk(5, 1'b1, 1'b0));
            end
            6'b000000: begin
                q.push_back(mk(1, 1'b0, 1'b0)); q.push_back(mk(6, 1'b0, 1'b0));
                q.push_back(mk(7, 1'b0, 1'b0));
            end
            6'b001000: begin
                q.push_back(mk(1, 1'b0, 1'b0)); q.push_back(mk(9, 1'b0, 1'b0));
                q.push_back(mk(10, 1'b0, 1'b0));
            end
            6'b000100: q.push_back(mk(1, 1'b0, 1'b0)); 
            6'b000010: q.push_back(mk(1, 1'b0, 1'b0));
            default:   q.push_back(mk(1, 1'b0, 1'b1));
        endcase
        if (op == 6'b000100) q.push_back(mk(8, 1'b0, 1'b0));
        if (op == 6'b000010) q.push_back(mk(11, 1'b0, 1'b0));
    endtask

    // Control word each named step must present:
    // {state, iord, mem_write, ir_write, pc_write, branch, pc_src,
    //  alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op}
    function automatic logic [19:0] model_out(input int st, input bit rdy, input bit ill);
        logic       io = 1'b0, mw = 1'b0, irw = 1'b0, pcw = 1'b0, br = 1'b0;
        logic       a = 1'b0, rd = 1'b0, m2r = 1'b0, rw = 1'b0;
        logic [1:0] ps = 2'b00, b = 2'b00, op = 2'b00;
        case (st)
            0:    begin b = 2'b01; irw = rdy; pcw = rdy; end
            1:    b = 2'b11;
            2, 9: begin a = 1'b1; b = 2'b10; end
            3:    io = 1'b1;
            4:    begin rw = 1'b1; m2r = 1'b1; end
            5:    begin io = 1'b1; mw = 1'b1; end
            6:    begin a = 1'b1; op = 2'b10; end
            7:    begin rw = 1'b1; rd = 1'b1; end
            8:    begin a = 1'b1; op = 2'b01; br = 1'b1; ps = 2'b01; end
            10:   rw = 1'b1;
            11:   begin pcw = 1'b1; ps = 2'b10; end
            default: ;
        endcase
        return {4'(st), io, mw, irw, pcw, br, ps, a, b, op, rd, m2r, rw, ill};
    endfunction

    function automatic logic [19:0] dut_word();
        return {state_o, iord, mem_write, ir_write, pc_write, branch, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};
    endfunction

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ill_cnt;
        int cnt_a;
        int cnt_b;
        logic [5:0] ops[6];

        tbl[0] = '{6'b100011, 5, '{0, 1, 2, 3, 4, 0}, 0};
        tbl[1] = '{6'b101011, 4, '{0, 1, 2, 5, 0, 0}, 0};
        tbl[2] = '{6'b000000, 4, '{0, 1, 6, 7, 0, 0}, 0};
        tbl[3] = '{6'b001000, 4, '{0, 1, 9, 10, 0, 0}, 0};
        tbl[4] = '{6'b000100, 3, '{0, 1, 8, 0, 0, 0}, 0};
        tbl[5] = '{6'b000010, 3, '{0, 1, 11, 0, 0, 0}, 0};
        tbl[6] = '{6'b111111, 2, '{0, 1, 0, 0, 0, 0}, 1};

        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b100011;

        // Reset state and lw with mem_ready held high.
        @(negedge clk);
        check("rst_state", state_o, 4'd0);
        check("rst_ir_write", ir_write, 1'b0);
        check("rst_pc_write", pc_write, 1'b0);
        check("rst_alu_src_b", alu_src_b, 2'b01);
        check("rst_reg_write", reg_write, 1'b0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("lw_state_c%0d", c), state_o, tbl[0].seq[c]);
            check($sformatf("lw_reg_write_c%0d", c), reg_write, (c == 4) ? 1'b1 : 1'b0);
            check($sformatf("lw_mem_to_reg_c%0d", c), mem_to_reg, (c == 4) ? 1'b1 : 1'b0);
            next_cycle();
        end

        // Table: every opcode with mem_ready tied high, back to back.
        apply_reset();
        for (int t = 0; t < 7; t++) begin
            opcode  = tbl[t].op;
            ill_cnt = 0;
            for (int c = 0; c < tbl[t].cycles; c++) begin
                @(negedge clk);
                check($sformatf("tbl%0d_state_c%0d", t, c), state_o, tbl[t].seq[c]);
                if (illegal_op) ill_cnt++;
                next_cycle();
            end
            check($sformatf("tbl%0d_back_to_fetch", t), state_o, 4'd0);
            check($sformatf("tbl%0d_illegal_cnt", t), ill_cnt, tbl[t].ill);
        end

        // sw with three wait cycles in MEMWR.
        apply_reset();
        opcode = 6'b101011;
        cnt_a  = 0;
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (mem_write) cnt_a++;
            if (c >= 3 && c <= 6) check($sformatf("sw_wait_state_c%0d", c), state_o, 4'd5);
            next_cycle();
        end
        check("sw_mem_write_cycles", cnt_a, 4);
        @(negedge clk);
        check("sw_after_fetch_state", state_o, 4'd1);
        next_cycle();

        // beq: branch controls in the third cycle, then FETCH.
        apply_reset();
        opcode = 6'b000100;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("beq_state", state_o, 4'd8);
        check("beq_branch", branch, 1'b1);
        check("beq_alu_op", alu_op, 2'b01);
        check("beq_pc_src", pc_src, 2'b01);
        next_cycle();
        @(negedge clk);
        check("beq_next_fetch", state_o, 4'd0);
        check("beq_branch_off", branch, 1'b0);
        next_cycle();

        // Unsupported opcode, then j on the jump-disabled instance.
        apply_reset();
        opcode = 6'b111111;
        @(negedge clk);
        check("ill_fetch_pulse", illegal_op, 1'b0);
        next_cycle();
        @(negedge clk);
        check("ill_decode_state", state_o, 4'd1);
        check("ill_decode_pulse", illegal_op, 1'b1);
        next_cycle();
        @(negedge clk);
        check("ill_next_state", state_o, 4'd0);
        check("ill_pulse_gone", illegal_op, 1'b0);

        apply_reset();
        opcode = 6'b000010;
        next_cycle();
        @(negedge clk);
        check("nj_decode_pulse", j_illegal_op, 1'b1);
        check("j_decode_no_pulse", illegal_op, 1'b0);
        next_cycle();
        @(negedge clk);
        check("nj_next_state", j_state_o, 4'd0);
        check("j_jump_state", state_o, 4'd11);
        check("j_pc_write", pc_write, 1'b1);
        check("j_pc_src", pc_src, 2'b10);
        next_cycle();

        // FETCH stalls two cycles on mem_ready, then single IR/PC pulses.
        apply_reset();
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("fw_state_c%0d", c), state_o, 4'd0);
            check($sformatf("fw_ir_write_c%0d", c), ir_write, 1'b0);
            check($sformatf("fw_pc_write_c%0d", c), pc_write, 1'b0);
            next_cycle();
        end
        mem_ready = 1'b1;
        cnt_a     = 0;
        cnt_b     = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ir_write) cnt_a++;
            if (pc_write) cnt_b++;
            next_cycle();
        end
        check("fw_ir_write_pulses", cnt_a, 1);
        check("fw_pc_write_pulses", cnt_b, 1);

        // Asynchronous reset in the middle of EXEC.
        apply_reset();
        opcode = 6'b000000;
        cnt_a  = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (reg_write) cnt_a++;
            next_cycle();
        end
        check("arst_exec_state", state_o, 4'd6);
        #2 rst = 1'b1;
        #1;
        check("arst_state_immediate", state_o, 4'd0);
        if (reg_write) cnt_a++;
        @(negedge clk);
        if (reg_write) cnt_a++;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (reg_write) cnt_a++;
            check($sformatf("arst_restart_c%0d", c), state_o, c);
            next_cycle();
        end
        check("arst_reg_write_never", cnt_a, 0);

        // Randomized run against the instruction-level model.
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        apply_reset();
        q.delete();
        for (int c = 0; c < 800; c++) begin
            if (q.size() == 0) begin
                int idx;
                idx = $urandom_range(0, 6);
                if (idx == 6) opcode = 6'($urandom());
                else          opcode = ops[idx];
                build_instr(opcode);
            end
            mem_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            check($sformatf("rand_c%0d_op%b", c, opcode), dut_word(),
                  model_out(q[0].st, mem_ready, q[0].ill));
            if (!(q[0].waits && !mem_ready)) void'(q.pop_front());
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
